// File: rtl/branch_predict_btb_if.sv
// Fetch-lookup / resolution-update bundle shared by the BTB and the pipeline.
// The pipeline (master) drives lookups and updates; the BTB (slave) answers them.
interface branch_predict_btb_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
);
  logic [WORD_W-1:0] pc_i;
  logic              pred_hit;
  logic              pred_taken;
  logic [WORD_W-1:0] pred_target;

  logic              upd_valid;
  logic [WORD_W-1:0] upd_pc;
  logic              upd_taken;
  logic [WORD_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [WORD_W-1:0] upd_pred_target;
  logic              invalidate;

  logic              mispredict;
  logic [WORD_W-1:0] correct_pc;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output pc_i, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, invalidate,
    input  pred_hit, pred_taken, pred_target, mispredict, correct_pc,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_i, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, invalidate,
    output pred_hit, pred_taken, pred_target, mispredict, correct_pc,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// zero-latency fetch lookup, resolution-time training and mispredict counters.
module branch_predict_btb #(
  parameter int         ENTRIES  = 16,
  parameter int         WORD_W   = 32,
  parameter int         CNT_W    = 32,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input logic CLK,
  input logic RST,
  branch_predict_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [WORD_W-1:0]  tgt_q [ENTRIES];
  logic [WORD_W-1:0]  tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, lk_taken, up_hit, mispred;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  always_comb begin
    lk_idx   = bus.pc_i[IDX_W+1:2];
    lk_tag   = bus.pc_i[WORD_W-1:IDX_W+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][1];
    up_idx   = bus.upd_pc[IDX_W+1:2];
    up_tag   = bus.upd_pc[WORD_W-1:IDX_W+2];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    mispred  = bus.upd_valid &&
               ((bus.upd_taken != bus.upd_pred_taken) ||
                (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
  end

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? tgt_q[lk_idx] : bus.pc_i + WORD_W'(4);
  assign bus.mispredict  = mispred;
  assign bus.correct_pc  = (bus.upd_valid && bus.upd_taken) ? bus.upd_target
                                                            : bus.upd_pc + WORD_W'(4);
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

  // Fetch never looks at the byte offset within a word.
  logic unused_pc_lo;
  assign unused_pc_lo = ^{bus.pc_i[1:0], bus.upd_pc[1:0]};

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    tgt_d         = tgt_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bus.upd_valid) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispred) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      if (up_hit) begin
        if (bus.upd_taken) begin
          ctr_d[up_idx] = sat_inc(ctr_q[up_idx]);
          tgt_d[up_idx] = bus.upd_target;
        end else begin
          ctr_d[up_idx] = sat_dec(ctr_q[up_idx]);
        end
      end else if (bus.upd_taken) begin
        // Taken miss evicts whatever aliased into this slot.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = bus.upd_target;
        ctr_d[up_idx]   = INIT_CTR;
      end
    end
    // A context flush overrides any allocation made in the same cycle.
    if (bus.invalidate) valid_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      ctr_q         <= ctr_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_btb.sv
// Directed bench for branch_predict_btb (ENTRIES=16, WORD_W=32, CNT_W=4):
// expectations are queued when stimulus is applied and drained at each sample point.
module tb_branch_predict_btb;
  logic CLK = 1'b0;
  logic RST;

  always #10 CLK = ~CLK;

  branch_predict_btb_if #(.WORD_W(32), .CNT_W(4)) bus ();

  branch_predict_btb #(
    .ENTRIES(16), .WORD_W(32), .CNT_W(4), .INIT_CTR(2'b10)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef enum int {S_HIT, S_TAKEN, S_TGT, S_MP, S_CPC, S_BR, S_MPC} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  int   br_m   = 0;
  int   mp_m   = 0;

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_HIT:   return {31'b0, bus.pred_hit};
      S_TAKEN: return {31'b0, bus.pred_taken};
      S_TGT:   return bus.pred_target;
      S_MP:    return {31'b0, bus.mispredict};
      S_CPC:   return bus.correct_pc;
      S_BR:    return 32'(bus.branch_cnt);
      default: return 32'(bus.mispred_cnt);
    endcase
  endfunction

  task automatic push(input string name, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      total++;
      assert (o === e.val) passed++;
      else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.name, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic hit, input logic tk, input logic [31:0] tgt);
    bus.pc_i = pc;
    #1;
    push({name, ".hit"},    S_HIT,   {31'b0, hit});
    push({name, ".taken"},  S_TAKEN, {31'b0, tk});
    push({name, ".target"}, S_TGT,   tgt);
    drain();
  endtask

  task automatic counters(input string name);
    push({name, ".branch_cnt"},  S_BR,  32'(br_m));
    push({name, ".mispred_cnt"}, S_MPC, 32'(mp_m));
    drain();
  endtask

  task automatic upd(input string name, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic exp_mp, input logic [31:0] exp_cpc);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
    #1;
    push({name, ".mispredict"}, S_MP,  {31'b0, exp_mp});
    push({name, ".correct_pc"}, S_CPC, exp_cpc);
    drain();
    tick();
    bus.upd_valid = 1'b0;
    br_m = (br_m + 1) % 16;
    if (exp_mp) mp_m = (mp_m + 1) % 16;
    counters(name);
  endtask

  initial begin
    RST                 = 1'b1;
    bus.pc_i            = 32'h40;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = 32'h40;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = 32'h0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = 32'h0;
    bus.invalidate      = 1'b0;
    tick();
    look("in_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    counters("in_reset");
    push("in_reset.mispredict", S_MP, 32'h0);
    push("in_reset.correct_pc", S_CPC, 32'h44);
    drain();
    tick();
    RST = 1'b0;
    tick();

    look("post_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    counters("post_reset");

    // First taken branch allocates; the same-cycle lookup still sees the old table.
    bus.pc_i = 32'h40;
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = 32'h40;
    bus.upd_taken       = 1'b1;
    bus.upd_target      = 32'h100;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = 32'h0;
    #1;
    push("same_cycle.hit", S_HIT, 32'h0);
    push("same_cycle.target", S_TGT, 32'h44);
    drain();
    bus.upd_valid = 1'b0;
    upd("alloc40", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100);
    look("alloc40", 32'h40, 1'b1, 1'b1, 32'h100);

    // Walk the counter down to strongly not-taken and past saturation.
    upd("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44);
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd("nt2", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44);
    upd("nt3", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44);
    look("nt3", 32'h40, 1'b1, 1'b0, 32'h44);
    upd("nt_ok", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44);
    upd("tk_from00", 32'h40, 1'b1, 32'h100, 1'b0, 32'h100, 1'b1, 32'h100);
    look("ctr01", 32'h40, 1'b1, 1'b0, 32'h44);
    upd("tk_to10", 32'h40, 1'b1, 32'h100, 1'b0, 32'h100, 1'b1, 32'h100);
    look("ctr10", 32'h40, 1'b1, 1'b1, 32'h100);
    upd("bad_target", 32'h40, 1'b1, 32'h120, 1'b1, 32'h104, 1'b1, 32'h120);
    upd("good_target", 32'h40, 1'b1, 32'h120, 1'b1, 32'h120, 1'b0, 32'h120);
    look("retarget", 32'h40, 1'b1, 1'b1, 32'h120);

    // 0x80 shares index 0 with 0x40 but carries a different tag.
    upd("alias80", 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'h300);
    upd("nt_miss48", 32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4C);
    look("no_alloc48", 32'h48, 1'b0, 1'b0, 32'h4C);

    bus.invalidate = 1'b1;
    upd("inv_upd200", 32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
    bus.invalidate = 1'b0;
    look("inv_200", 32'h200, 1'b0, 1'b0, 32'h204);
    look("inv_80", 32'h80, 1'b0, 1'b0, 32'h84);

    upd("re80", 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    upd("re44", 32'h44, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
    look("re44", 32'h44, 1'b1, 1'b1, 32'h500);

    // Asynchronous reset between edges, held across an edge carrying an update.
    #3;
    RST  = 1'b1;
    br_m = 0;
    mp_m = 0;
    look("async_rst", 32'h44, 1'b0, 1'b0, 32'h48);
    counters("async_rst");
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = 32'h80;
    bus.upd_taken      = 1'b1;
    bus.upd_target     = 32'h300;
    bus.upd_pred_taken = 1'b0;
    tick();
    bus.upd_valid = 1'b0;
    RST = 1'b0;
    tick();
    look("rst_discard", 32'h80, 1'b0, 1'b0, 32'h84);
    counters("rst_discard");

    for (int i = 0; i < 16; i++) begin
      upd("wrap", 32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4C);
    end
    push("wrap_final.branch_cnt", S_BR, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
